// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, status bit positions
// and the controller state encoding.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_SLL = 4'b1011;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SRL = 4'b1101;
    localparam logic [3:0] OP_SRA = 4'b1110;

    localparam int ST_ZERO  = 7;
    localparam int ST_OVF   = 6;
    localparam int ST_CARRY = 5;
    localparam int ST_NEG   = 4;
    localparam int ST_ODD   = 3;
    localparam int ST_DIVZ  = 2;
    localparam int ST_ILL   = 1;

    localparam logic [7:0] STATUS_RESET = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FINISH
    } alu_state_e;

    // Division by zero is resolved immediately, so only a real divide iterates.
    function automatic logic is_iter_op(input logic [3:0] op, input logic divisor_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative datapath: unsigned shift-add multiply and restoring divide,
// one bit per step, WIDTH steps per operation.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             step,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] hi_q, lo_q, opb_q;
    logic             is_div_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (step) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign last = step && (count_q == LAST_CNT);

    // Multiply keeps the partial product in hi and the unconsumed multiplier in lo;
    // divide keeps the partial remainder in hi and shifts quotient bits into lo.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        hi_d      = mul_sum[WIDTH:1];
        lo_d      = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (!rem_diff[WIDTH]) begin
                hi_d = rem_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hi_q     <= '0;
            lo_q     <= op_a;
            opb_q    <= op_b;
            is_div_q <= is_div;
        end else if (step) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative mul/div,
// sequenced by an IDLE/ITER/FINISH controller with a registered done pulse.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_ctrl,
    input  logic [WIDTH-1:0] ALU_operand_1,
    input  logic [WIDTH-1:0] ALU_operand_2,
    input  logic [SHW-1:0]   shamnt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] ALU_result_hi,
    output logic [7:0]       ALU_status
);

    alu_state_e       state_q, state_d;
    logic             done_q;
    logic [WIDTH-1:0] res_q, res_hi_q;
    logic [7:0]       status_q;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [SHW-1:0]   sh_q;

    logic             accept, iter_start, iter_load, iter_step, iter_last, op_is_div;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    logic [31:0]      sh_mod;
    logic [WIDTH:0]   add_sum, sub_diff;
    logic [WIDTH-1:0] res_d, res_hi_d;
    logic             ovf_d, carry_d, divz_d, ill_d;
    logic [7:0]       status_d;

    function automatic logic [7:0] pack_status(input logic [WIDTH-1:0] r, input logic ovf,
                                               input logic cy, input logic dz, input logic ill);
        logic [7:0] s;
        s           = '0;
        s[ST_ZERO]  = (r == '0);
        s[ST_OVF]   = ovf;
        s[ST_CARRY] = cy;
        s[ST_NEG]   = r[WIDTH-1];
        s[ST_ODD]   = r[0];
        s[ST_DIVZ]  = dz;
        s[ST_ILL]   = ill;
        return s;
    endfunction

    // A start coinciding with done is ignored: busy still covers that cycle.
    assign accept     = start && (state_q == IDLE) && !done_q;
    assign iter_start = is_iter_op(ALU_ctrl, ALU_operand_2 == '0);
    assign iter_load  = accept && iter_start;
    assign iter_step  = (state_q == ITER);
    assign op_is_div  = (ALU_ctrl == OP_DIV);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (iter_load),
        .is_div (op_is_div),
        .op_a   (ALU_operand_1),
        .op_b   (ALU_operand_2),
        .step   (iter_step),
        .last   (iter_last),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = iter_start ? ITER : FINISH;
            ITER:    if (iter_last) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= ALU_ctrl;
            a_q  <= ALU_operand_1;
            b_q  <= ALU_operand_2;
            sh_q <= shamnt;
        end
    end

    assign sh_mod   = 32'(sh_q) % 32'(WIDTH);
    assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res_d    = '0;
        res_hi_d = '0;
        ovf_d    = 1'b0;
        carry_d  = 1'b0;
        divz_d   = 1'b0;
        ill_d    = 1'b0;
        case (op_q)
            OP_AND: res_d = a_q & b_q;
            OP_OR:  res_d = a_q | b_q;
            OP_XOR: res_d = a_q ^ b_q;
            OP_NOR: res_d = ~(a_q | b_q);
            OP_ADD: begin
                res_d   = add_sum[WIDTH-1:0];
                carry_d = add_sum[WIDTH];
                ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_d   = sub_diff[WIDTH-1:0];
                carry_d = ~sub_diff[WIDTH];
                ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL: res_d = a_q << sh_mod;
            OP_SRL: res_d = a_q >> sh_mod;
            OP_SRA: res_d = $signed(a_q) >>> sh_mod;
            OP_MUL: begin
                res_d    = iter_lo;
                res_hi_d = iter_hi;
                ovf_d    = (iter_hi != '0);
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    res_d    = '1;
                    res_hi_d = a_q;
                    divz_d   = 1'b1;
                end else begin
                    res_d    = iter_lo;
                    res_hi_d = iter_hi;
                end
            end
            default: ill_d = 1'b1;
        endcase
        status_d = pack_status(res_d, ovf_d, carry_d, divz_d, ill_d);
    end

    // Results are committed on the FINISH->IDLE edge, which is also when done rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            res_q    <= '0;
            res_hi_q <= '0;
            status_q <= STATUS_RESET;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FINISH);
            if (state_q == FINISH) begin
                res_q    <= res_d;
                res_hi_q <= res_hi_d;
                status_q <= status_d;
            end
        end
    end

    assign busy          = (state_q != IDLE) || done_q;
    assign done          = done_q;
    assign ALU_result    = res_q;
    assign ALU_result_hi = res_hi_q;
    assign ALU_status    = status_q;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (legal values 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-006 SHALL have port ALU_ctrl  input  4  operation select.
REQ-007 SHALL have ports ALU_operand_1 and ALU_operand_2  input  WIDTH  operands, sampled with start.
REQ-008 SHALL have port shamnt  input  SHW  shift amount, sampled with start.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse when result/status update.
REQ-011 SHALL have port ALU_result  output  WIDTH  low result / quotient.
REQ-012 SHALL have port ALU_result_hi  output  WIDTH  high product / remainder; 0 for other ops.
REQ-013 SHALL have port ALU_status  output  8  flags: [7] zero, [6] overflow, [5] carry, [4] negative, [3] odd (result[0]), [2] divide-by-zero, [1] illegal op, [0] always 0.

Function
REQ-014 Opcodes SHALL be: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt (signed), 1010 xor, 1011 sll, 1100 nor, 1101 srl, 1110 sra, 1000 mul (unsigned), 1001 div (unsigned); all others illegal.
REQ-015 FSM SHALL have states IDLE, ITER, FINISH; IDLE->FINISH on start with a single-cycle op; IDLE->ITER on start with mul/div (divisor non-zero); ITER->FINISH after WIDTH iterations; FINISH->IDLE unconditionally.
REQ-016 Single-cycle ops SHALL assert done exactly 2 cycles after the start edge; mul/div SHALL assert done exactly WIDTH+2 cycles after it.
REQ-017 busy SHALL be high from the cycle after start is accepted through the done cycle inclusive; start while busy=1 SHALL be ignored with no effect.
REQ-018 Operands, ALU_ctrl and shamnt SHALL be captured at start; later input changes SHALL not affect the in-flight operation.
REQ-019 ALU_result, ALU_result_hi and ALU_status SHALL update only on the done cycle and hold until the next done.
REQ-020 add/sub SHALL compute in WIDTH+1 bits; carry = bit WIDTH for add, borrow-free (op1>=op2 unsigned) for sub; overflow = signed two's-complement overflow.
REQ-021 mul SHALL be iterative shift-add, 2*WIDTH-bit product split hi/lo; overflow=1 iff ALU_result_hi!=0; carry=0.
REQ-022 div SHALL be iterative restoring; quotient to ALU_result, remainder to ALU_result_hi.
REQ-023 div with ALU_operand_2=0 SHALL take the single-cycle path: ALU_result all-ones, ALU_result_hi=ALU_operand_1, status[2]=1.
REQ-024 Illegal op SHALL take the single-cycle path: ALU_result=0, ALU_result_hi=0, status[1]=1, status[7]=1.
REQ-025 Shifts SHALL use shamnt modulo WIDTH; sra SHALL sign-fill; overflow and carry SHALL be 0 for logic, shift and slt ops.
REQ-026 Zero flag SHALL reflect ALU_result only; negative = ALU_result[WIDTH-1].
REQ-027 start asserted in the same cycle as done (busy=1) SHALL be ignored; start in the FINISH->IDLE following cycle SHALL be accepted.

Reset
REQ-028 rst assertion SHALL immediately force state IDLE, busy=0, done=0, ALU_result=0, ALU_result_hi=0, ALU_status=8'h80.
REQ-029 rst mid-operation SHALL abort the operation with no done pulse; first start after rst deassertion SHALL behave as from power-up.

Structure
REQ-030 Package alu_pkg SHALL hold opcode constants, status bit indices and the FSM state enumeration.
REQ-031 Iterative mul/div datapath SHALL be sub-module alu_muldiv_iter (load, step, count, hi/lo registers); single-cycle ops stay in multicycle_alu.

Verification
REQ-032 add 32'h7FFFFFFF + 1 -> done at cycle 2, result 32'h80000000, status[6]=1, [4]=1, [5]=0.
REQ-033 mul 32'h00010000 * 32'h00010000 -> done at cycle 34, result 0, result_hi 1, status[6]=1, [7]=1.
REQ-034 div 100 / 7 -> done at cycle 34, result 14, result_hi 2, status[3]=0; div 5/0 -> cycle 2, result 32'hFFFFFFFF, result_hi 5, status[2]=1.
REQ-035 sra 32'h80000000 by 4 -> 32'hF8000000; slt -1 vs 1 -> result 1.
REQ-036 start during mul ITER with different operands -> ignored, original product delivered; rst at cycle 10 of div -> no done, outputs 0, status 8'h80.
REQ-037 Repeat REQ-032..034 with WIDTH=8 and WIDTH=64; latency WIDTH+2 for mul/div.
